// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/data/parity/stop
// on device-generated clock falls, then samples the device ack bit.
module ps2_host_tx #(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int TO_W           = 20
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  if (CLK_HZ <= 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      INHIBIT_CYCLES >= (1 << TO_W) || TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_bad_params
    $error("ps2_host_tx: counter width too small or bad cycle parameters");
  end

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam logic [TO_W-1:0] INHIBIT_LAST = TO_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t          state, state_nxt;
  logic [TO_W-1:0] count, count_nxt;
  logic [3:0]      bitcnt, bitcnt_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            parity, parity_nxt;
  logic            ack_bit, ack_bit_nxt;
  logic            clock_oe_nxt, data_oe_nxt;
  logic            ack_ok_nxt, error_nxt;

  logic            clock_p0, clock_p1, clock_p2;
  logic            data_p0, data_p1;
  logic            fall;
  logic            timeout;

  // Stage p0/p1: two-flop synchronisers; p2 holds the previous clock sample
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      clock_p0 <= 1'b1;
      clock_p1 <= 1'b1;
      clock_p2 <= 1'b1;
      data_p0  <= 1'b1;
      data_p1  <= 1'b1;
    end else begin
      clock_p0 <= ps2_clock;
      clock_p1 <= clock_p0;
      clock_p2 <= clock_p1;
      data_p0  <= ps2_data;
      data_p1  <= data_p0;
    end
  end

  assign fall    = clock_p2 & ~clock_p1;
  assign timeout = (count == TIMEOUT_LAST);

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    bitcnt_nxt   = bitcnt;
    shreg_nxt    = shreg;
    parity_nxt   = parity;
    ack_bit_nxt  = ack_bit;
    clock_oe_nxt = ps2_clock_oe;
    data_oe_nxt  = ps2_data_oe;
    ack_ok_nxt   = ack_ok;
    error_nxt    = error;

    case (state)
      IDLE: begin
        clock_oe_nxt = 1'b0;
        data_oe_nxt  = 1'b0;
        if (tx_valid) begin
          shreg_nxt    = tx_data;
          parity_nxt   = odd_parity(tx_data);
          ack_ok_nxt   = 1'b0;
          error_nxt    = 1'b0;
          count_nxt    = '0;
          clock_oe_nxt = 1'b1;
          state_nxt    = INHIBIT;
        end
      end

      INHIBIT: begin
        if (count == INHIBIT_LAST) begin
          clock_oe_nxt = 1'b0;
          data_oe_nxt  = 1'b1;
          count_nxt    = '0;
          bitcnt_nxt   = '0;
          state_nxt    = SEND;
        end else begin
          count_nxt = count + TO_W'(1);
        end
      end

      SEND: begin
        if (timeout) begin
          clock_oe_nxt = 1'b0;
          data_oe_nxt  = 1'b0;
          ack_bit_nxt  = 1'b1;
          ack_ok_nxt   = 1'b0;
          error_nxt    = 1'b1;
          state_nxt    = DONE;
        end else begin
          count_nxt = count + TO_W'(1);
          if (fall) begin
            bitcnt_nxt = bitcnt + 4'd1;
            if (bitcnt < 4'd8) begin
              data_oe_nxt = ~shreg[bitcnt[2:0]];
            end else if (bitcnt == 4'd8) begin
              data_oe_nxt = ~parity;
            end else if (bitcnt == 4'd9) begin
              data_oe_nxt = 1'b0;
            end else begin
              // Eleventh fall: the device is driving its ack bit
              ack_bit_nxt = data_p1;
              data_oe_nxt = 1'b0;
              state_nxt   = WAIT_IDLE;
            end
          end
        end
      end

      WAIT_IDLE: begin
        clock_oe_nxt = 1'b0;
        data_oe_nxt  = 1'b0;
        if (timeout) begin
          ack_bit_nxt = 1'b1;
          ack_ok_nxt  = 1'b0;
          error_nxt   = 1'b1;
          state_nxt   = DONE;
        end else if (clock_p1 && data_p1) begin
          // Status is registered on entry so it is valid during the done pulse
          ack_ok_nxt = ~ack_bit;
          error_nxt  = ack_bit;
          state_nxt  = DONE;
        end else begin
          count_nxt = count + TO_W'(1);
        end
      end

      DONE: begin
        clock_oe_nxt = 1'b0;
        data_oe_nxt  = 1'b0;
        state_nxt    = IDLE;
      end

      default: begin
        clock_oe_nxt = 1'b0;
        data_oe_nxt  = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      bitcnt       <= '0;
      ps2_clock_oe <= 1'b0;
      ps2_data_oe  <= 1'b0;
      ack_ok       <= 1'b0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      count        <= count_nxt;
      bitcnt       <= bitcnt_nxt;
      ps2_clock_oe <= clock_oe_nxt;
      ps2_data_oe  <= data_oe_nxt;
      ack_ok       <= ack_ok_nxt;
      error        <= error_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    shreg   <= shreg_nxt;
    parity  <= parity_nxt;
    ack_bit <= ack_bit_nxt;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out and acks (or not);
// expected frames and status are queued at request time and checked at done.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 2000;
  localparam int LO  = 8;
  localparam int HI  = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       dev_ack;
    logic       parity;
    logic       exp_ack_ok;
    logic       exp_error;
    logic [1:0] mode;  // 0 normal, 1 request while busy, 2 silent device, 3 reset abort
  } vec_t;

  typedef struct packed {
    logic [10:0] frame;
    logic        ack_ok;
    logic        error;
    logic        chk_frame;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clock, ps2_data;
  logic       ps2_clock_oe, ps2_data_oe;
  logic       tx_ready, busy, done, ack_ok, error;

  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  vec_t tbl[5];
  vec_t v;

  assign ps2_clock = ~(ps2_clock_oe | dev_clk_low);
  assign ps2_data  = ~(ps2_data_oe | dev_data_low);

  always #5 clk_in = ~clk_in;

  ps2_host_tx #(
    .CLK_HZ(50_000_000),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .TO_W(20)
  ) dut (
    .clk_in(clk_in),
    .reset_n(reset_n),
    .ps2_clock(ps2_clock),
    .ps2_data(ps2_data),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .ack_ok(ack_ok),
    .error(error)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check32(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic run_xfer(input vec_t tv);
    exp_t        e;
    logic [10:0] got;
    int          cnt;
    int          waited;
    int          hi_cnt;
    bit          seen;

    got = '0;
    @(negedge clk_in);
    check1("ready_before_req", tx_ready, 1'b1);
    tx_data  = tv.data;
    tx_valid = 1'b1;
    if (tv.mode != 2'd3) begin
      e.frame     = {1'b1, tv.parity, tv.data, 1'b0};
      e.ack_ok    = tv.exp_ack_ok;
      e.error     = tv.exp_error;
      e.chk_frame = (tv.mode != 2'd2);
      sb.push_back(e);
    end
    @(negedge clk_in);
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Inhibit phase: count cycles with the clock line pulled low
    cnt  = 0;
    seen = 1'b0;
    for (int k = 0; k < INH + 40; k++) begin
      if (ps2_clock_oe) cnt++;
      if (ps2_data_oe && !ps2_clock_oe) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    check1("start_bit_driven", seen, 1'b1);
    check32("inhibit_len", cnt, INH);

    if (tv.mode != 2'd2) begin
      got[0] = ps2_data;
      for (int i = 1; i <= 10; i++) begin
        repeat (HI) @(negedge clk_in);
        dev_clk_low = 1'b1;
        repeat (LO) @(negedge clk_in);
        dev_clk_low = 1'b0;
        got[i] = ps2_data;
        if (tv.mode == 2'd1 && i == 4) begin
          check1("ready_low_busy", tx_ready, 1'b0);
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          @(negedge clk_in);
          tx_valid = 1'b0;
          tx_data  = 8'h00;
        end
        if (tv.mode == 2'd3 && i == 5) begin
          reset_n = 1'b0;
          @(negedge clk_in);
          check1("rst_mid_clock_oe", ps2_clock_oe, 1'b0);
          check1("rst_mid_data_oe", ps2_data_oe, 1'b0);
          check1("rst_mid_busy", busy, 1'b0);
          check1("rst_mid_ready", tx_ready, 1'b1);
          reset_n = 1'b1;
          repeat (5) @(negedge clk_in);
          check1("rst_mid_no_done", done, 1'b0);
          return;
        end
      end
      if (tv.dev_ack) dev_data_low = 1'b1;
      repeat (HI) @(negedge clk_in);
      dev_clk_low = 1'b1;
      repeat (LO) @(negedge clk_in);
      dev_clk_low = 1'b0;
      @(negedge clk_in);
      dev_data_low = 1'b0;
    end

    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < TMO + 100; k++) begin
      if (done) begin
        seen   = 1'b1;
        waited = k;
        break;
      end
      @(negedge clk_in);
    end
    check1("done_seen", seen, 1'b1);
    if (sb.size() == 0) begin
      check32("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      if (e.chk_frame) check32("frame_bits", 32'(got), 32'(e.frame));
      check1("ack_ok_on_done", ack_ok, e.ack_ok);
      check1("error_on_done", error, e.error);
      check1("clock_oe_on_done", ps2_clock_oe, 1'b0);
      check1("data_oe_on_done", ps2_data_oe, 1'b0);
      if (tv.mode == 2'd2) check32("timeout_cycles", waited, TMO);
      @(negedge clk_in);
      check1("done_one_cycle", done, 1'b0);
      check1("ready_after_done", tx_ready, 1'b1);
      check1("busy_after_done", busy, 1'b0);
      check1("error_holds", error, e.error);
    end

    if (tv.mode == 2'd1) begin
      hi_cnt = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk_in);
        if (ps2_clock_oe || busy) hi_cnt++;
      end
      check32("busy_req_ignored", hi_cnt, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check1("rst_clock_oe", ps2_clock_oe, 1'b0);
    check1("rst_data_oe", ps2_data_oe, 1'b0);
    check1("rst_ready", tx_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_ack_ok", ack_ok, 1'b0);
    check1("rst_error", error, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_in);

    //               data   ack   par   ack_ok err   mode
    tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0};
    tbl[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[4] = '{8'hF4, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1};
    for (int i = 0; i < 5; i++) run_xfer(tbl[i]);

    v = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2};
    run_xfer(v);
    v = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3};
    run_xfer(v);
    v = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    run_xfer(v);

    check32("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte per request to the attached keyboard, such as 0xED (set LEDs) or 0xFF (reset). It runs on the same ps2_clock/ps2_data pair as the existing scancode receiver, driving the open-drain lines low through output-enable signals. It sits beside the keyboard receiver under the keyboard controller and exposes a valid/ready byte interface plus completion and error status.

## Interface
- CLK_HZ, 50_000_000: system clock frequency (documentation only).
- INHIBIT_CYCLES, 5000: cycles ps2_clock is held low before the request (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles from request-to-send to ack (15 ms at 50 MHz).
- TO_W, 20: width of the timeout/inhibit counter. Must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk_in, input, 1: system clock. Everything is posedge clk_in.
- reset_n, input, 1: synchronous, active-low reset.
- ps2_clock, input, 1: raw PS/2 clock line (asynchronous).
- ps2_data, input, 1: raw PS/2 data line (asynchronous).
- ps2_clock_oe, output, 1: 1 pulls the clock line low. 0 releases it.
- ps2_data_oe, output, 1: 1 pulls the data line low. 0 releases it.
- tx_data, input, 8: byte to send.
- tx_valid, input, 1: request. The byte is accepted in the cycle where tx_valid && tx_ready.
- tx_ready, output, 1: high only in IDLE.
- busy, output, 1: high in every state except IDLE. The receiver ignores scancodes while busy.
- done, output, 1: one-cycle pulse at the end of a transfer.
- ack_ok, output, 1: valid on done. 1 means the device acked (ack bit = 0).
- error, output, 1: valid on done. 1 means timeout or missing ack. Holds until the next accept.

## Operation
- Input synchronisation:
  - ps2_clock and ps2_data each pass through 2-flop synchronisers.
  - A falling edge is detected as sync_prev=1, sync_cur=0, giving a one-cycle fall strobe.
- Frame: start(0), d0..d7 LSB first, odd parity (~^tx_data), stop(1), then the device's ack bit.
- State machine:
  - IDLE: both oe=0, tx_ready=1. On accept:
    - latch tx_data into shreg and compute parity.
    - clear error and ack_ok.
    - counter := 0.
    - go to INHIBIT.
  - INHIBIT: ps2_clock_oe=1. Counter increments. At counter == INHIBIT_CYCLES-1:
    - ps2_data_oe := 1 (start bit).
    - ps2_clock_oe := 0.
    - counter := 0, bitcnt := 0.
    - go to SEND.
  - SEND: counter increments every cycle. On each fall strobe bitcnt increments:
    - bitcnt 0..7: ps2_data_oe := ~shreg[bitcnt].
    - bitcnt 8: ps2_data_oe := ~parity.
    - bitcnt 9: ps2_data_oe := 0 (stop bit).
    - bitcnt 10: sample the synchronised ps2_data into ack_bit and go to WAIT_IDLE.
  - WAIT_IDLE: both oe=0. When both synchronised lines are 1, go to DONE.
  - DONE: for one cycle:
    - done=1.
    - ack_ok = ~ack_bit.
    - error = ack_bit.
    - then go to IDLE.
- Timeout: in SEND or WAIT_IDLE, counter reaching TIMEOUT_CYCLES-1 forces:
  - both oe := 0.
  - error := 1, ack_ok := 0.
  - done pulse next cycle, then IDLE. No retry.
- tx_valid outside IDLE is ignored, not queued.
- Reset values: ps2_clock_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_ok=0, error=0, state=IDLE, counters=0.
- Reset mid-transfer releases both lines within 1 cycle and abandons the frame.

## Timing
- Accept at cycle T: ps2_clock_oe=1 from T+1 through T+INHIBIT_CYCLES.
- At T+INHIBIT_CYCLES+1: ps2_data_oe=1 and ps2_clock_oe=0 together.
- Each data change lands 3 cycles after the raw ps2_clock falls (2 sync cycles + 1 register). This is well inside the device's ~30 µs low phase.
- The ack is sampled on the 11th fall strobe. done follows at least 2 cycles after both lines are observed high.
- busy deasserts in the same cycle that tx_ready asserts (the cycle after done).

## Test plan
- Send 0xED with a bench device model that acks (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000):
  - line low for exactly 20 cycles.
  - bits sampled on rising edges = 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - one done pulse with ack_ok=1, error=0.
- Send 0xFF with ack: data bits all 1, parity=1, ack_ok=1.
- Send 0x00: parity bit=1. The device model withholds the ack (line high) → done with ack_ok=0, error=1.
- Device never clocks after the request → at TIMEOUT_CYCLES: error=1, done pulse, both oe=0, tx_ready=1.
- Pulse tx_valid with 0x55 while busy → ignored. Only the first byte (0xF4) appears on the wire.
- Assert reset_n=0 during SEND bit 4 → next cycle both oe=0, busy=0, tx_ready=1. A new 0xED transfer then completes correctly.
